// File: rtl/core_apb_arb.sv
// N-channel valid/ready to APB master arbiter with fixed-priority or round-robin
// grant selection and an optional pready timeout that completes hung transfers with an error.
module core_apb_arb #(
    parameter int N_CH     = 2,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      req_valid,
    output logic [N_CH-1:0]      req_ready,
    input  logic [N_CH*32-1:0]   req_addr,
    input  logic [N_CH-1:0]      req_write,
    input  logic [N_CH*32-1:0]   req_wdata,
    input  logic [N_CH*4-1:0]    req_wstrb,
    output logic [31:0]          req_rdata,
    output logic                 req_err,
    output logic                 psel,
    output logic                 penable,
    input  logic                 pready,
    output logic [31:0]          paddr,
    output logic                 pwrite,
    output logic [31:0]          pwdata,
    output logic [3:0]           pwstrb,
    input  logic [31:0]          prdata,
    input  logic                 pslverr
);

    localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]    state_r;
    logic [GW-1:0] grant_r;
    logic [GW-1:0] rr_ptr_r;
    logic [CW-1:0] count_r;
    logic          psel_r;
    logic          penable_r;
    logic [31:0]   paddr_r;
    logic          pwrite_r;
    logic [31:0]   pwdata_r;
    logic [3:0]    pwstrb_r;

    logic [GW-1:0] start_s;
    logic [GW-1:0] idx_s;
    logic [GW-1:0] arb_g_s;
    logic          found_s;
    logic          timeout_hit_s;
    logic          access_done_s;
    logic [GW-1:0] rr_next_s;

    // Grant search: fixed priority is a round-robin search that always starts at channel 0
    always_comb begin
        start_s = (ARB_MODE != 0) ? rr_ptr_r : '0;
        idx_s   = '0;
        arb_g_s = '0;
        found_s = 1'b0;
        for (int off = 0; off < N_CH; off++) begin
            idx_s = GW'((int'(start_s) + off) % N_CH);
            if (!found_s && req_valid[idx_s]) begin
                arb_g_s = idx_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Completion decode; a pready in the final counted cycle takes precedence over the timeout
    always_comb begin
        timeout_hit_s = (TIMEOUT != 0) && !pready && (count_r == TO_LAST);
        access_done_s = (state_r == ST_ACCESS) && !rst && (pready || timeout_hit_s);
        rr_next_s     = (grant_r == GW'(N_CH - 1)) ? '0 : grant_r + 1'b1;
        req_rdata     = prdata;
        if (!access_done_s) begin
            req_err = 1'b0;
        end else if (pready) begin
            req_err = pslverr;
        end else begin
            req_err = 1'b1;
        end
    end

    // Single-cycle completion strobe to the granted channel only
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (access_done_s && (grant_r == GW'(i))) begin
                req_ready[i] = 1'b1;
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    // APB FSM; payload is captured at grant so requestors may change it afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            grant_r   <= '0;
            rr_ptr_r  <= '0;
            count_r   <= '0;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            paddr_r   <= 32'h0000_0000;
            pwrite_r  <= 1'b0;
            pwdata_r  <= 32'h0000_0000;
            pwstrb_r  <= 4'b0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        grant_r   <= arb_g_s;
                        paddr_r   <= req_addr[32*arb_g_s +: 32];
                        pwrite_r  <= req_write[arb_g_s];
                        pwdata_r  <= req_wdata[32*arb_g_s +: 32];
                        pwstrb_r  <= req_write[arb_g_s] ? req_wstrb[4*arb_g_s +: 4] : 4'b0000;
                        psel_r    <= 1'b1;
                        penable_r <= 1'b0;
                        state_r   <= ST_SETUP;
                    end else begin
                        psel_r    <= 1'b0;
                        penable_r <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    penable_r <= 1'b1;
                    count_r   <= '0;
                    state_r   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (access_done_s) begin
                        psel_r    <= 1'b0;
                        penable_r <= 1'b0;
                        state_r   <= ST_IDLE;
                        if (ARB_MODE != 0) begin
                            rr_ptr_r <= rr_next_s;
                        end else begin
                            rr_ptr_r <= rr_ptr_r;
                        end
                    end else if (count_r != {CW{1'b1}}) begin
                        count_r <= count_r + 1'b1;
                    end else begin
                        count_r <= count_r;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    psel_r    <= 1'b0;
                    penable_r <= 1'b0;
                end
            endcase
        end
    end

    assign psel    = psel_r;
    assign penable = penable_r;
    assign paddr   = paddr_r;
    assign pwrite  = pwrite_r;
    assign pwdata  = pwdata_r;
    assign pwstrb  = pwstrb_r;

endmodule

// File: tb/tb_core_apb_arb.sv
// Directed bench: a 2-channel fixed-priority instance and a 3-channel round-robin
// instance with TIMEOUT=4, each driven through hand-computed APB scenarios.
module tb_core_apb_arb;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    // Instance 0: N_CH=2, fixed priority, no timeout
    logic [1:0]  v0, rdy0, write0;
    logic [63:0] addr0, wdata0;
    logic [7:0]  wstrb0;
    logic [31:0] rdata0, paddr0, pwdata0, prdata0;
    logic        err0, psel0, penable0, pready0, pwrite0, pslverr0;
    logic [3:0]  pwstrb0;

    // Instance 1: N_CH=3, round-robin, TIMEOUT=4
    logic [2:0]  v1, rdy1, write1;
    logic [95:0] addr1, wdata1;
    logic [11:0] wstrb1;
    logic [31:0] rdata1, paddr1, pwdata1, prdata1;
    logic        err1, psel1, penable1, pready1, pwrite1, pslverr1;
    logic [3:0]  pwstrb1;

    core_apb_arb #(.N_CH(2), .ARB_MODE(0), .TIMEOUT(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(v0), .req_ready(rdy0), .req_addr(addr0), .req_write(write0),
        .req_wdata(wdata0), .req_wstrb(wstrb0), .req_rdata(rdata0), .req_err(err0),
        .psel(psel0), .penable(penable0), .pready(pready0), .paddr(paddr0),
        .pwrite(pwrite0), .pwdata(pwdata0), .pwstrb(pwstrb0), .prdata(prdata0),
        .pslverr(pslverr0)
    );

    core_apb_arb #(.N_CH(3), .ARB_MODE(1), .TIMEOUT(4)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(v1), .req_ready(rdy1), .req_addr(addr1), .req_write(write1),
        .req_wdata(wdata1), .req_wstrb(wstrb1), .req_rdata(rdata1), .req_err(err1),
        .psel(psel1), .penable(penable1), .pready(pready1), .paddr(paddr1),
        .pwrite(pwrite1), .pwdata(pwdata1), .pwstrb(pwstrb1), .prdata(prdata1),
        .pslverr(pslverr1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        v0 = 2'b00; write0 = 2'b00; addr0 = 64'h0; wdata0 = 64'h0; wstrb0 = 8'h00;
        pready0 = 1'b0; prdata0 = 32'h0; pslverr0 = 1'b0;
        v1 = 3'b000; write1 = 3'b000; addr1 = 96'h0; wdata1 = 96'h0; wstrb1 = 12'h000;
        pready1 = 1'b0; prdata1 = 32'h0; pslverr1 = 1'b0;

        // reset state
        tick();
        tick();
        #1;
        check("rst_psel0", 32'(psel0), 32'd0);
        check("rst_penable0", 32'(penable0), 32'd0);
        check("rst_paddr0", paddr0, 32'h0);
        check("rst_pwdata0", pwdata0, 32'h0);
        check("rst_pwstrb0", 32'(pwstrb0), 32'd0);
        check("rst_pwrite0", 32'(pwrite0), 32'd0);
        check("rst_ready0", 32'(rdy0), 32'd0);
        check("rst_psel1", 32'(psel1), 32'd0);

        // 1: single read on ch0
        rst = 1'b0;
        v0 = 2'b01; addr0[31:0] = 32'h0000_0100; write0 = 2'b00;
        wdata0[31:0] = 32'hAAAA_5555; wstrb0[3:0] = 4'hF;
        prdata0 = 32'hDEAD_BEEF; pready0 = 1'b1;
        tick();
        #1;
        check("t1_setup_psel", 32'(psel0), 32'd1);
        check("t1_setup_penable", 32'(penable0), 32'd0);
        check("t1_setup_ready", 32'(rdy0), 32'd0);
        check("t1_paddr", paddr0, 32'h0000_0100);
        check("t1_pwstrb_read", 32'(pwstrb0), 32'd0);
        tick();
        #1;
        check("t1_access_penable", 32'(penable0), 32'd1);
        check("t1_ready", 32'(rdy0), 32'd1);
        check("t1_rdata", rdata0, 32'hDEAD_BEEF);
        check("t1_err", 32'(err0), 32'd0);
        v0 = 2'b00;
        tick();
        #1;
        check("t1_idle_psel", 32'(psel0), 32'd0);
        check("t1_idle_ready", 32'(rdy0), 32'd0);

        // 2: write on ch1 with three wait states, payload changed after grant
        v0 = 2'b10; write0 = 2'b10;
        addr0[63:32] = 32'h0000_2004; wdata0[63:32] = 32'h1234_5678; wstrb0[7:4] = 4'b0011;
        pready0 = 1'b0;
        tick();
        #1;
        check("t2_setup_psel", 32'(psel0), 32'd1);
        addr0[63:32] = 32'hFFFF_0000; wdata0[63:32] = 32'h0; wstrb0[7:4] = 4'b1100; write0 = 2'b00;
        for (int c = 1; c <= 4; c++) begin
            tick();
            pready0 = (c == 4);
            #1;
            check("t2_paddr", paddr0, 32'h0000_2004);
            check("t2_pwdata", pwdata0, 32'h1234_5678);
            check("t2_pwstrb", 32'(pwstrb0), 32'h3);
            check("t2_pwrite", 32'(pwrite0), 32'd1);
            check("t2_ready", 32'(rdy0), (c == 4) ? 32'h2 : 32'h0);
        end
        check("t2_err", 32'(err0), 32'd0);
        v0 = 2'b00;
        tick();
        #1;
        check("t2_idle_psel", 32'(psel0), 32'd0);

        // 3: fixed priority, both channels valid continuously
        v0 = 2'b11; write0 = 2'b00; addr0 = {32'h0000_0400, 32'h0000_0300}; pready0 = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            tick();
            #1;
            check("t3_ready", 32'(rdy0), 32'h1);
            check("t3_paddr", paddr0, 32'h0000_0300);
            tick();
        end
        v0 = 2'b00;

        // 4: round-robin, all three channels valid continuously
        v1 = 3'b111; addr1 = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000}; pready1 = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            tick();
            #1;
            check("t4_ready", 32'(rdy1), 32'(1 << (t % 3)));
            check("t4_paddr", paddr1, 32'h1000 * 32'((t % 3) + 1));
            tick();
        end

        // 5: timeout with pready held low
        v1 = 3'b010; addr1[63:32] = 32'h0000_5000; pready1 = 1'b0;
        tick();
        #1;
        check("t5_setup_psel", 32'(psel1), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            #1;
            check("t5_ready", 32'(rdy1), (c == 4) ? 32'h2 : 32'h0);
            check("t5_err", 32'(err1), (c == 4) ? 32'd1 : 32'd0);
        end
        v1 = 3'b000;
        tick();
        #1;
        check("t5_after_psel", 32'(psel1), 32'd0);
        check("t5_after_penable", 32'(penable1), 32'd0);

        // 6a: slave error alongside pready
        v0 = 2'b01; write0 = 2'b01; pready0 = 1'b1; pslverr0 = 1'b1;
        tick();
        tick();
        #1;
        check("t6_ready", 32'(rdy0), 32'h1);
        check("t6_slverr", 32'(err0), 32'd1);
        v0 = 2'b00; pslverr0 = 1'b0;
        tick();

        // 6b: reset during ACCESS; pointer sits at 2 from the previous completion
        v1 = 3'b111; addr1 = {32'h0000_C000, 32'h0000_B000, 32'h0000_A000}; pready1 = 1'b0;
        tick();
        #1;
        check("t6_rr_grant2", paddr1, 32'h0000_C000);
        tick();
        rst = 1'b1;
        #1;
        check("t6_rst_ready", 32'(rdy1), 32'd0);
        tick();
        #1;
        check("t6_rst_psel", 32'(psel1), 32'd0);
        check("t6_rst_penable", 32'(penable1), 32'd0);
        check("t6_rst_ready_after", 32'(rdy1), 32'd0);
        rst = 1'b0;
        tick();
        #1;
        check("t6_rr_reset_grant0", paddr1, 32'h0000_A000);
        tick();
        pready1 = 1'b1;
        #1;
        check("t6_rearb_ready", 32'(rdy1), 32'h1);
        v1 = 3'b000;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
